req_tenure_ctrl: RTL
====================

// Module: req_tenure_ctrl
// PURPOSE
//  Upstream request generator for the 4-way fsm_full arbiter. Each of 4 clients issues a one-cycle
//  start with a beat count; the block raises req_N, holds it through the granted tenure, drops it
//  after the last beat, and waits for gnt_N to clear before accepting the next start on that channel.
//  Guarantees the arbiter sees clean, bounded req levels instead of raw client strobes.
// PARAMETERS
//  LEN_W    4   width of each per-channel beat-count field; tenure = len+1 granted cycles (1..2^LEN_W)
//  TIMEOUT  16  max cycles in REQ without grant before abandoning (only with REQ_TIMEOUT_EN)
//  TO_W     5   timeout counter width; must satisfy 2^TO_W > TIMEOUT
// PORTS
//  clock     in   1        single clock, all flops posedge
//  reset     in   1        asynchronous, active-low reset
//  start     in   4        start[N]: one-cycle pulse, begin tenure on channel N
//  len       in   4*LEN_W  len[N*LEN_W +: LEN_W]: beat count minus one, sampled with start[N]
//  gnt_0..3  in   1 each   grants from the arbiter
//  req_0..3  out  1 each   requests to the arbiter
//  busy      out  4        busy[N]=1 whenever channel N is not IDLE
//  done      out  4        done[N]: one-cycle pulse when channel N returns to IDLE after a full tenure
//  timeout   out  4        timeout[N]: one-cycle pulse when channel N abandons a request
// BEHAVIOUR
//  - Reset (reset=0, async): all channels IDLE; req_*, busy, done, timeout = 0; counters = 0.
//  - 4 independent identical channels; no cross-channel interaction (arbiter resolves priority).
//  - Channel states: IDLE, REQ, XFER, RELEASE.
//   IDLE:    start=1 -> load beat_cnt=len, to_cnt=0, -> REQ. req rises the cycle after start is sampled.
//   REQ:     req=1. gnt=1 -> XFER (that cycle counts as beat 0). else to_cnt++;
//            to_cnt==TIMEOUT-1 with gnt=0 -> IDLE, req=0, timeout pulse (REQ_TIMEOUT_EN only).
//   XFER:    req=1. each cycle with gnt=1: if beat_cnt==0 -> RELEASE else beat_cnt--.
//            gnt=0 in XFER freezes beat_cnt (no beat consumed), no abort.
//   RELEASE: req=0. wait gnt=0 -> IDLE with done pulse same edge. gnt still high: stay.
//  - Beat counting: beat in REQ->XFER edge counts; total granted cycles with req high = len+1.
//    Arbiter gnt lags req by 2 edges and lingers after req drop; RELEASE absorbs that lag.
//  - start while busy: ignored, no queueing, len not resampled.
//  - gnt while IDLE or RELEASE: ignored (no beat, no error).
//  - done and timeout never assert together for a channel; done/timeout are registered pulses.
//  - len=all-ones: 2^LEN_W beats, counter does not wrap past 0.
//  - Reset mid-tenure: req drops immediately (async), no done/timeout pulse.
// CONFIGURATION
//  REQ_TIMEOUT_EN defined: REQ timeout path active as above, TO_W-bit counter per channel.
//  REQ_TIMEOUT_EN undefined: REQ waits indefinitely for grant; timeout[3:0] tied 0; no to_cnt flops.
//  TIMEOUT/TO_W unused when undefined.
// STRUCTURE
//  Package fsm_full_pkg: ch_state_t enum {IDLE,REQ,XFER,RELEASE} (2 bits), NUM_CH=4 constant.
//  Sub-module req_tenure_chan: one channel FSM + beat/timeout counters, ports start,len,gnt ->
//  req,busy,done,timeout; top instantiates 4 via generate and maps vector bits to req_N/gnt_N.
// TESTING (bench drives gnt from a real fsm_full instance unless stated)
//  1 reset low mid-REQ on ch0 -> req_0=0, busy=0 at once; after release start ignored until next edge.
//  2 start[1]=1,len=2, no other reqs -> req_1 high 1 cycle later; exactly 3 gnt_1-high beats with
//    req_1=1; req_1 drops; done[1] pulses once gnt_1 falls; busy[1] low next cycle.
//  3 start[0] and start[3] same cycle, len=0 each -> ch0 granted first, done[0]; ch3 then granted,
//    done[3]; both req never dropped before their single beat.
//  4 start[2] again while busy[2]=1 with len=7 -> ignored; tenure length stays original len.
//  5 REQ_TIMEOUT_EN, TIMEOUT=16, gnt_2 held 0 by stub -> timeout[2] pulses on 16th REQ cycle,
//    req_2=0, done[2] never pulses; without macro req_2 stays high indefinitely, timeout=0.
//  6 stub drops gnt for 2 cycles mid-XFER, len=3 -> beat count frozen; still 4 granted beats total.

Source files
------------

// File: rtl/req_tenure_ctrl_pkg.sv
// Shared types and constants for the 4-way request tenure controller.
package fsm_full_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } ch_state_t;

endpackage

// File: rtl/req_tenure_ctrl_if.sv
// Client/arbiter-facing bundle of the tenure controller: starts and lengths in,
// per-channel req/gnt pairs, and per-channel status pulses out.
interface req_tenure_ctrl_if
  import fsm_full_pkg::*;
#(
  parameter int LEN_W = 4
);

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*LEN_W-1:0] len;
  logic                    gnt_0;
  logic                    gnt_1;
  logic                    gnt_2;
  logic                    gnt_3;
  logic                    req_0;
  logic                    req_1;
  logic                    req_2;
  logic                    req_3;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       timeout;

  modport master (
    output start, len, gnt_0, gnt_1, gnt_2, gnt_3,
    input  req_0, req_1, req_2, req_3, busy, done, timeout
  );

  modport slave (
    input  start, len, gnt_0, gnt_1, gnt_2, gnt_3,
    output req_0, req_1, req_2, req_3, busy, done, timeout
  );

endinterface

// File: rtl/req_tenure_ctrl_chan.sv
// One request channel: turns a start strobe into a clean req level held for len+1 granted beats.
// REQ_TIMEOUT_EN adds an abandon path when no grant arrives within TIMEOUT cycles.
//
// state   | meaning
// IDLE    | waiting for start, req low
// REQ     | req high, no beat granted yet
// XFER    | req high, at least one beat consumed
// RELEASE | req low, waiting for the arbiter's lagging gnt to clear
module req_tenure_chan
  import fsm_full_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_REQ     = 2'(REQ);
  localparam logic [1:0] S_XFER    = 2'(XFER);
  localparam logic [1:0] S_RELEASE = 2'(RELEASE);

  if (2**TO_W <= TIMEOUT) begin : g_to_w_check
    $error("TO_W too narrow to hold TIMEOUT");
  end

  logic [1:0]       state, state_nx;
  logic [LEN_W-1:0] beat_cnt, beat_nx;
  logic             done_r, done_nx;

`ifdef REQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            to_r, to_nx;
`endif

  always_comb begin
    state_nx = state;
    beat_nx  = beat_cnt;
    done_nx  = 1'b0;
`ifdef REQ_TIMEOUT_EN
    to_cnt_nx = to_cnt;
    to_nx     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_REQ;
          beat_nx  = len;
`ifdef REQ_TIMEOUT_EN
          to_cnt_nx = '0;
`endif
        end
      end
      S_REQ: begin
        // The granting edge out of REQ is itself a beat, so len=0 goes straight to RELEASE.
        if (gnt) begin
          if (beat_cnt == '0) begin
            state_nx = S_RELEASE;
          end else begin
            beat_nx  = beat_cnt - 1'b1;
            state_nx = S_XFER;
          end
        end
`ifdef REQ_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          state_nx = S_IDLE;
          to_nx    = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
`endif
      end
      S_XFER: begin
        if (gnt) begin
          if (beat_cnt == '0) begin
            state_nx = S_RELEASE;
          end else begin
            beat_nx = beat_cnt - 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (!gnt) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_nx;
      done_r   <= done_nx;
    end
  end

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      to_r   <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nx;
      to_r   <= to_nx;
    end
  end

  assign timeout = to_r;
`else
  assign timeout = 1'b0;
`endif

  assign req  = (state == S_REQ) || (state == S_XFER);
  assign busy = (state != S_IDLE);
  assign done = done_r;

endmodule

// File: rtl/req_tenure_ctrl.sv
// Four independent request-tenure channels in front of the 4-way arbiter.
// Build with REQ_TIMEOUT_EN to let channels abandon an ungranted request.
module req_tenure_ctrl
  import fsm_full_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  req_tenure_ctrl_if.slave  bus
);

  logic [NUM_CH-1:0] gnt_v;
  logic [NUM_CH-1:0] req_v;

  assign gnt_v = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    req_tenure_chan #(
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .start   (bus.start[i]),
      .len     (bus.len[i*LEN_W +: LEN_W]),
      .gnt     (gnt_v[i]),
      .req     (req_v[i]),
      .busy    (bus.busy[i]),
      .done    (bus.done[i]),
      .timeout (bus.timeout[i])
    );
  end

  assign bus.req_0 = req_v[0];
  assign bus.req_1 = req_v[1];
  assign bus.req_2 = req_v[2];
  assign bus.req_3 = req_v[3];

endmodule
